// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) / divide (restoring, on magnitudes) engine
// feeding the HI/LO registers; one iteration per clock, WIDTH iterations per operation.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             MULTcontrol,
    input  logic             DIVcontrol,
    output logic             busy,
    output logic             done,
    output logic             Div0,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int unsigned CW = 6;

    typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_DONE} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   acc_q;     // mult: upper partial product; div: remainder
    logic [WIDTH-1:0] mq_q;      // mult: multiplier/lower product; div: dividend/quotient
    logic             qm1_q;
    logic [WIDTH-1:0] opb_q;     // multiplicand or divisor magnitude
    logic             sa_q;
    logic             sb_q;
    logic             busy_q;
    logic             done_q;
    logic             div0_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   mul_acc_d;
    logic [WIDTH-1:0] mul_mq_d;
    logic             mul_qm1_d;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic             div_ok;
    logic [WIDTH-1:0] div_rem_d;
    logic [WIDTH-1:0] div_q_d;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;
    logic             last_step;

    // One Booth step: add/subtract sign-extended multiplicand, then arithmetic shift right
    always_comb begin
        mul_sum = acc_q;
        unique case ({mq_q[0], qm1_q})
            2'b01:   mul_sum = acc_q + {opb_q[WIDTH-1], opb_q};
            2'b10:   mul_sum = acc_q - {opb_q[WIDTH-1], opb_q};
            default: mul_sum = acc_q;
        endcase
        mul_acc_d = {mul_sum[WIDTH], mul_sum[WIDTH:1]};
        mul_mq_d  = {mul_sum[0], mq_q[WIDTH-1:1]};
        mul_qm1_d = mq_q[0];
    end

    // One restoring-divide step on magnitudes; the true trial difference always fits WIDTH+1 signed bits
    always_comb begin
        rem_sh    = {acc_q[WIDTH-1:0], mq_q[WIDTH-1]};
        trial     = rem_sh - {1'b0, opb_q};
        div_ok    = ~trial[WIDTH];
        div_rem_d = div_ok ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        div_q_d   = {mq_q[WIDTH-2:0], div_ok};
        quo_fix   = (sa_q ^ sb_q) ? -div_q_d : div_q_d;
        rem_fix   = sa_q ? -div_rem_d : div_rem_d;
        last_step = (cnt_q == CW'(WIDTH - 1));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mq_q    <= '0;
            qm1_q   <= 1'b0;
            opb_q   <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            div0_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (MULTcontrol) begin
                        acc_q   <= '0;
                        mq_q    <= A;
                        qm1_q   <= 1'b0;
                        opb_q   <= B;
                        busy_q  <= 1'b1;
                        state_q <= S_MULT;
                    end else if (DIVcontrol) begin
                        if (B == '0) begin
                            done_q  <= 1'b1;
                            div0_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            acc_q   <= '0;
                            mq_q    <= A[WIDTH-1] ? -A : A;
                            opb_q   <= B[WIDTH-1] ? -B : B;
                            sa_q    <= A[WIDTH-1];
                            sb_q    <= B[WIDTH-1];
                            busy_q  <= 1'b1;
                            state_q <= S_DIV;
                        end
                    end
                end
                S_MULT: begin
                    cnt_q <= cnt_q + CW'(1);
                    acc_q <= mul_acc_d;
                    mq_q  <= mul_mq_d;
                    qm1_q <= mul_qm1_d;
                    if (last_step) begin
                        hi_q    <= mul_acc_d[WIDTH-1:0];
                        lo_q    <= mul_mq_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DIV: begin
                    cnt_q <= cnt_q + CW'(1);
                    acc_q <= {1'b0, div_rem_d};
                    mq_q  <= div_q_d;
                    if (last_step) begin
                        hi_q    <= rem_fix;
                        lo_q    <= quo_fix;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    div0_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign Div0 = div0_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and seeded-random checks of mult_div_unit: results, latency, Div0, protocol and reset abort.
module tb_mult_div_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        MULTcontrol = 1'b0;
    logic        DIVcontrol = 1'b0;
    logic        busy, done, Div0;
    logic [31:0] HI, LO;

    int checks = 0;
    int failures = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .A(A), .B(B),
        .MULTcontrol(MULTcontrol), .DIVcontrol(DIVcontrol),
        .busy(busy), .done(done), .Div0(Div0), .HI(HI), .LO(LO)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Start an operation and count rising edges (start edge = 1) until done is seen.
    // A DIVcontrol pulse with scrambled operands is injected after edge inj (0 = none).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic m,
                          input logic d, input int inj, output int n);
        @(negedge clock);
        A = a; B = b; MULTcontrol = m; DIVcontrol = d;
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clock);
            n++;
            @(negedge clock);
            MULTcontrol = 1'b0;
            DIVcontrol  = (n == inj);
            if (n == inj) begin
                A = 32'h1357_9BDF;
                B = 32'h0000_0003;
            end
            if (done) break;
        end
    endtask

    initial begin
        int n;
        int extra;
        logic [31:0] ra, rb;
        longint p;
        int qi, ri;

        repeat (2) @(negedge clock);
        chk("reset_state", {27'd0, busy, done, Div0, 34'd0} | {HI, LO}, 64'd0);
        reset = 1'b0;

        // Basic multiply with latency and busy observation
        @(negedge clock);
        A = 32'd7; B = 32'hFFFF_FFFD; MULTcontrol = 1'b1;
        @(posedge clock);
        @(negedge clock);
        MULTcontrol = 1'b0;
        chk("mul_busy_after_start", {63'd0, busy}, 64'd1);
        n = 1;
        for (int k = 0; k < 100 && !done; k++) begin
            @(posedge clock); n++; @(negedge clock);
        end
        chk("mul_latency", 64'(n), 64'd33);
        chk("mul_7x-3", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFEB);
        chk("mul_busy_at_done", {63'd0, busy}, 64'd0);
        @(negedge clock);
        chk("mul_done_one_cycle", {62'd0, done, Div0}, 64'd0);
        chk("mul_hilo_stable", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFEB);

        run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 0, n);
        chk("mul_min_x_min", {HI, LO}, 64'h4000_0000_0000_0000);
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 0, n);
        chk("mul_-1x1", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFF);

        // Signed divide
        run_op(32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1, 0, n);
        chk("div_latency", 64'(n), 64'd33);
        chk("div_-7/2", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
        chk("div_-7/2_div0", {63'd0, Div0}, 64'd0);
        run_op(32'd7, 32'hFFFF_FFFE, 1'b0, 1'b1, 0, n);
        chk("div_7/-2", {HI, LO}, 64'h0000_0001_FFFF_FFFD);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 0, n);
        chk("div_min/-1", {HI, LO}, 64'h0000_0000_8000_0000);
        chk("div_min/-1_div0", {63'd0, Div0}, 64'd0);

        // Divide by zero after preloading HI=5, LO=9 via 95/10
        run_op(32'd95, 32'd10, 1'b0, 1'b1, 0, n);
        chk("preload_95/10", {HI, LO}, 64'h0000_0005_0000_0009);
        run_op(32'd1, 32'd0, 1'b0, 1'b1, 0, n);
        chk("div0_latency", 64'(n), 64'd1);
        chk("div0_flag", {62'd0, done, Div0}, 64'd3);
        chk("div0_hilo_kept", {HI, LO}, 64'h0000_0005_0000_0009);
        @(negedge clock);
        chk("div0_clears", {62'd0, done, Div0}, 64'd0);

        // Both starts: multiply wins
        run_op(32'd6, 32'd3, 1'b1, 1'b1, 0, n);
        chk("both_starts_latency", 64'(n), 64'd33);
        chk("both_starts_mul", {HI, LO}, 64'd18);

        // DIVcontrol and operand changes during a multiply are ignored
        run_op(32'd3, 32'd4, 1'b1, 1'b0, 10, n);
        chk("busy_start_latency", 64'(n), 64'd33);
        chk("busy_start_ignored", {HI, LO}, 64'd12);
        extra = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (done) extra++;
        end
        chk("no_second_done", 64'(extra), 64'd0);

        // Reset in the middle of a divide
        @(negedge clock);
        A = 32'd100; B = 32'd7; DIVcontrol = 1'b1;
        @(posedge clock);
        @(negedge clock);
        DIVcontrol = 1'b0;
        repeat (14) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("reset_abort", {29'd0, busy, done, Div0, HI, LO}, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        run_op(32'hFFFF_FFFB, 32'hFFFF_FFFA, 1'b1, 1'b0, 0, n);
        chk("post_reset_latency", 64'(n), 64'd33);
        chk("post_reset_mul", {HI, LO}, 64'd30);

        // Seeded random pairs against a 64-bit signed reference
        for (int i = 0; i < 150; i++) begin
            ra = $urandom;
            rb = (i % 3 == 0) ? 32'($signed(16'($urandom))) : $urandom;
            p = longint'($signed(ra)) * longint'($signed(rb));
            run_op(ra, rb, 1'b1, 1'b0, 0, n);
            chk("rand_mul", {HI, LO}, 64'(p));
            if (rb == 32'd0) rb = 32'd1;
            if (ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd3;
            qi = $signed(ra) / $signed(rb);
            ri = $signed(ra) % $signed(rb);
            run_op(ra, rb, 1'b0, 1'b1, 0, n);
            chk("rand_div", {HI, LO}, {32'(ri), 32'(qi)});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
